// File: rtl/trace_r3_monitor_pkg.sv
// Shared constants, trace payload type and l.nop hook decoder for the per-core trace monitor.
package trace_r3_monitor_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INSN_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned HOOK_K_W  = 16;
    localparam int unsigned CHAR_W    = 8;

    localparam logic [HOOK_K_W-1:0]  NOP_OPCODE = 16'h1500;
    localparam logic [HOOK_K_W-1:0]  NOP_EXIT   = 16'h0001;
    localparam logic [HOOK_K_W-1:0]  NOP_REPORT = 16'h0002;
    localparam logic [HOOK_K_W-1:0]  NOP_PUTC   = 16'h0004;
    localparam logic [REG_IDX_W-1:0] R3_IDX     = 5'd3;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [INSN_W-1:0]    insn;
        logic                 wb_en;
        logic [REG_IDX_W-1:0] wb_reg;
        logic [XLEN-1:0]      wb_data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        HOOK_NONE   = 2'd0,
        HOOK_EXIT   = 2'd1,
        HOOK_REPORT = 2'd2,
        HOOK_PUTC   = 2'd3
    } hook_e;

    // Classify a retired trace entry as one of the simulation hooks.
    function automatic hook_e decode_hook(input trace_entry_t entry);
        hook_e hook;
        hook = HOOK_NONE;
        if (entry.valid && (entry.insn[INSN_W-1:HOOK_K_W] == NOP_OPCODE)) begin
            unique case (entry.insn[HOOK_K_W-1:0])
                NOP_EXIT:   hook = HOOK_EXIT;
                NOP_REPORT: hook = HOOK_REPORT;
                NOP_PUTC:   hook = HOOK_PUTC;
                default:    hook = HOOK_NONE;
            endcase
        end
        return hook;
    endfunction

endpackage

// File: rtl/trace_r3_monitor_r3_shadow.sv
// Shadow copy of GPR r3, updated from retired writebacks targeting r3.
module trace_r3_monitor_r3_shadow
    import trace_r3_monitor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_wb_en,
    input  logic [REG_IDX_W-1:0] i_wb_reg,
    input  logic [XLEN-1:0]      i_wb_data,
    output logic [XLEN-1:0]      o_r3
);

    logic            w_hit;
    logic [XLEN-1:0] w_r3_next;
    logic [XLEN-1:0] r_r3;

    always_comb begin
        w_hit     = i_enable && i_wb_en && (i_wb_reg == R3_IDX);
        w_r3_next = r_r3;
        if (w_hit) begin
            w_r3_next = i_wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r3 <= '0;
        end else begin
            r_r3 <= w_r3_next;
        end
    end

    assign o_r3 = r_r3;

endmodule

// File: rtl/trace_r3_monitor.sv
// Per-core trace monitor: r3 shadow, l.nop exit/report/putc hooks, sticky termination
// with frozen cycle count, and the cross-core termination AND.
module trace_r3_monitor
    import trace_r3_monitor_pkg::*;
#(
    parameter int unsigned ID             = 0,
    parameter int unsigned TERM_CROSS_NUM = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [XLEN-1:0]           wb_pc,
    input  logic [INSN_W-1:0]         wb_insn,
    input  logic                      wb_en,
    input  logic [REG_IDX_W-1:0]      wb_reg,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [TERM_CROSS_NUM-1:0] termination_all,
    output logic [XLEN-1:0]           r3,
    output logic                      termination,
    output logic                      all_terminated,
    output logic [XLEN-1:0]           exit_code,
    output logic [XLEN-1:0]           exit_pc,
    output logic [XLEN-1:0]           cycle_count,
    output logic                      report_valid,
    output logic [XLEN-1:0]           report_value,
    output logic                      putc_valid,
    output logic [CHAR_W-1:0]         putc_char,
    output logic [XLEN-1:0]           core_id
);

    trace_entry_t    w_entry;
    hook_e           w_hook;
    logic [XLEN-1:0] w_r3;

    logic              r_termination;
    logic [XLEN-1:0]   r_exit_code;
    logic [XLEN-1:0]   r_exit_pc;
    logic [XLEN-1:0]   r_cycle_count;
    logic              r_report_valid;
    logic [XLEN-1:0]   r_report_value;
    logic              r_putc_valid;
    logic [CHAR_W-1:0] r_putc_char;

    logic              w_termination_next;
    logic [XLEN-1:0]   w_exit_code_next;
    logic [XLEN-1:0]   w_exit_pc_next;
    logic [XLEN-1:0]   w_cycle_count_next;
    logic              w_report_valid_next;
    logic [XLEN-1:0]   w_report_value_next;
    logic              w_putc_valid_next;
    logic [CHAR_W-1:0] w_putc_char_next;

    assign w_entry = '{
        valid:   enable,
        pc:      wb_pc,
        insn:    wb_insn,
        wb_en:   wb_en,
        wb_reg:  wb_reg,
        wb_data: wb_data
    };

    assign w_hook = decode_hook(w_entry);

    trace_r3_monitor_r3_shadow u_r3_shadow (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (w_entry.valid),
        .i_wb_en   (w_entry.wb_en),
        .i_wb_reg  (w_entry.wb_reg),
        .i_wb_data (w_entry.wb_data),
        .o_r3      (w_r3)
    );

    // Hooks see r3 as it stood before this edge; l.nop never writes a GPR.
    always_comb begin
        w_termination_next  = r_termination;
        w_exit_code_next    = r_exit_code;
        w_exit_pc_next      = r_exit_pc;
        w_cycle_count_next  = r_cycle_count;
        w_report_valid_next = 1'b0;
        w_report_value_next = r_report_value;
        w_putc_valid_next   = 1'b0;
        w_putc_char_next    = r_putc_char;

        if (!r_termination) begin
            w_cycle_count_next = r_cycle_count + XLEN'(1);
        end

        unique case (w_hook)
            HOOK_EXIT: begin
                if (!r_termination) begin
                    w_termination_next = 1'b1;
                    w_exit_code_next   = w_r3;
                    w_exit_pc_next     = w_entry.pc;
                end
            end
            HOOK_REPORT: begin
                w_report_valid_next = 1'b1;
                w_report_value_next = w_r3;
            end
            HOOK_PUTC: begin
                w_putc_valid_next = 1'b1;
                w_putc_char_next  = w_r3[CHAR_W-1:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_termination  <= 1'b0;
            r_exit_code    <= '0;
            r_exit_pc      <= '0;
            r_cycle_count  <= '0;
            r_report_valid <= 1'b0;
            r_report_value <= '0;
            r_putc_valid   <= 1'b0;
            r_putc_char    <= '0;
        end else begin
            r_termination  <= w_termination_next;
            r_exit_code    <= w_exit_code_next;
            r_exit_pc      <= w_exit_pc_next;
            r_cycle_count  <= w_cycle_count_next;
            r_report_valid <= w_report_valid_next;
            r_report_value <= w_report_value_next;
            r_putc_valid   <= w_putc_valid_next;
            r_putc_char    <= w_putc_char_next;
        end
    end

    assign r3             = w_r3;
    assign termination    = r_termination;
    assign exit_code      = r_exit_code;
    assign exit_pc        = r_exit_pc;
    assign cycle_count    = r_cycle_count;
    assign report_valid   = r_report_valid;
    assign report_value   = r_report_value;
    assign putc_valid     = r_putc_valid;
    assign putc_char      = r_putc_char;
    assign core_id        = XLEN'(ID);
    assign all_terminated = &termination_all;

endmodule

// File: tb/tb_trace_r3_monitor.sv
// Directed bench for trace_r3_monitor: r3 shadow, hooks, termination, cross AND, async reset.
module tb_trace_r3_monitor;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] wb_pc;
    logic [31:0] wb_insn;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [1:0]  termination_all;
    logic [31:0] r3;
    logic        termination;
    logic        all_terminated;
    logic [31:0] exit_code;
    logic [31:0] exit_pc;
    logic [31:0] cycle_count;
    logic        report_valid;
    logic [31:0] report_value;
    logic        putc_valid;
    logic [7:0]  putc_char;
    logic [31:0] core_id;

    int total;
    int bad;
    int unsigned edge_cnt;
    int unsigned frozen_cnt;

    trace_r3_monitor #(.ID(5), .TERM_CROSS_NUM(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .wb_pc           (wb_pc),
        .wb_insn         (wb_insn),
        .wb_en           (wb_en),
        .wb_reg          (wb_reg),
        .wb_data         (wb_data),
        .termination_all (termination_all),
        .r3              (r3),
        .termination     (termination),
        .all_terminated  (all_terminated),
        .exit_code       (exit_code),
        .exit_pc         (exit_pc),
        .cycle_count     (cycle_count),
        .report_valid    (report_valid),
        .report_value    (report_value),
        .putc_valid      (putc_valid),
        .putc_char       (putc_char),
        .core_id         (core_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of clock edges since the last reset.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we, input logic [4:0] rg,
                         input logic [31:0] data, input logic [31:0] insn, input logic [31:0] pc);
        enable  = en;
        wb_en   = we;
        wb_reg  = rg;
        wb_data = data;
        wb_insn = insn;
        wb_pc   = pc;
        step();
        enable  = 1'b0;
        wb_en   = 1'b0;
        wb_reg  = 5'd0;
        wb_data = 32'd0;
        wb_insn = 32'd0;
        wb_pc   = 32'd0;
    endtask

    task automatic test_reset();
        total++; if (r3 !== 32'd0) begin bad++; $display("FAIL reset_r3 got=%h exp=0", r3); end
        total++; if (termination !== 1'b0) begin bad++; $display("FAIL reset_term got=%b exp=0", termination); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
        total++; if (report_valid !== 1'b0 || putc_valid !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", report_valid, putc_valid); end
        total++; if (core_id !== 32'd5) begin bad++; $display("FAIL core_id got=%0d exp=5", core_id); end
    endtask

    task automatic test_putc();
        drive(1'b1, 1'b1, 5'd3, 32'h41, 32'h9c600041, 32'h10);
        total++; if (r3 !== 32'h41) begin bad++; $display("FAIL putc_r3 got=%h exp=41", r3); end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15000004, 32'h14);
        total++; if (putc_valid !== 1'b1) begin bad++; $display("FAIL putc_valid got=%b exp=1", putc_valid); end
        total++; if (putc_char !== 8'h41) begin bad++; $display("FAIL putc_char got=%h exp=41", putc_char); end
        total++; if (report_valid !== 1'b0) begin bad++; $display("FAIL putc_no_report got=%b exp=0", report_valid); end
        step();
        total++; if (putc_valid !== 1'b0) begin bad++; $display("FAIL putc_width got=%b exp=0", putc_valid); end
    endtask

    task automatic test_r3_filter();
        drive(1'b1, 1'b1, 5'd4, 32'hDEAD, 32'h0, 32'h18);
        total++; if (r3 !== 32'h41) begin bad++; $display("FAIL filter_reg4 got=%h exp=41", r3); end
        drive(1'b0, 1'b1, 5'd3, 32'hBEEF, 32'h0, 32'h1c);
        total++; if (r3 !== 32'h41) begin bad++; $display("FAIL filter_disabled got=%h exp=41", r3); end
        drive(1'b1, 1'b0, 5'd3, 32'hCAFE, 32'h0, 32'h20);
        total++; if (r3 !== 32'h41) begin bad++; $display("FAIL filter_no_wben got=%h exp=41", r3); end
    endtask

    task automatic test_report();
        drive(1'b1, 1'b1, 5'd3, 32'h12345678, 32'h0, 32'h24);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15000002, 32'h28);
        total++; if (report_valid !== 1'b1) begin bad++; $display("FAIL report_valid got=%b exp=1", report_valid); end
        total++; if (report_value !== 32'h12345678) begin bad++; $display("FAIL report_value got=%h exp=12345678", report_value); end
        step();
        total++; if (report_valid !== 1'b0) begin bad++; $display("FAIL report_width got=%b exp=0", report_valid); end
    endtask

    task automatic test_other_hooks();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15000003, 32'h2c);
        total++; if (report_valid !== 1'b0 || putc_valid !== 1'b0 || termination !== 1'b0) begin
            bad++; $display("FAIL other_k got=%b%b%b exp=000", report_valid, putc_valid, termination); end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15010004, 32'h30);
        total++; if (putc_valid !== 1'b0) begin bad++; $display("FAIL non_nop got=%b exp=0", putc_valid); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'h15000001, 32'h34);
        total++; if (termination !== 1'b0) begin bad++; $display("FAIL exit_disabled got=%b exp=0", termination); end
    endtask

    task automatic test_exit();
        drive(1'b1, 1'b1, 5'd3, 32'd7, 32'h0, 32'h38);
        total++; if (cycle_count !== edge_cnt) begin bad++; $display("FAIL count_running got=%0d exp=%0d", cycle_count, edge_cnt); end
        for (int i = 0; i < 100 && edge_cnt < 50; i++) step();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15000001, 32'h100);
        frozen_cnt = edge_cnt;
        total++; if (termination !== 1'b1) begin bad++; $display("FAIL exit_term got=%b exp=1", termination); end
        total++; if (exit_code !== 32'd7) begin bad++; $display("FAIL exit_code got=%0d exp=7", exit_code); end
        total++; if (exit_pc !== 32'h100) begin bad++; $display("FAIL exit_pc got=%h exp=100", exit_pc); end
        total++; if (cycle_count !== frozen_cnt) begin bad++; $display("FAIL exit_count got=%0d exp=%0d", cycle_count, frozen_cnt); end
        for (int i = 0; i < 10; i++) step();
        total++; if (cycle_count !== frozen_cnt) begin bad++; $display("FAIL count_frozen got=%0d exp=%0d", cycle_count, frozen_cnt); end
        drive(1'b1, 1'b1, 5'd3, 32'd9, 32'h0, 32'h104);
        total++; if (r3 !== 32'd9) begin bad++; $display("FAIL r3_after_term got=%0d exp=9", r3); end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15000001, 32'h200);
        total++; if (exit_code !== 32'd7 || exit_pc !== 32'h100) begin
            bad++; $display("FAIL second_exit got=%0d/%h exp=7/100", exit_code, exit_pc); end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h15000002, 32'h204);
        total++; if (report_valid !== 1'b1 || report_value !== 32'd9) begin
            bad++; $display("FAIL report_after_term got=%b/%0d exp=1/9", report_valid, report_value); end
    endtask

    task automatic test_cross();
        termination_all = 2'b01;
        #1;
        total++; if (all_terminated !== 1'b0) begin bad++; $display("FAIL cross_01 got=%b exp=0", all_terminated); end
        termination_all = 2'b11;
        #1;
        total++; if (all_terminated !== 1'b1) begin bad++; $display("FAIL cross_11 got=%b exp=1", all_terminated); end
        termination_all = 2'b10;
        #1;
        total++; if (all_terminated !== 1'b0) begin bad++; $display("FAIL cross_10 got=%b exp=0", all_terminated); end
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        #1;
        total++; if (termination !== 1'b0) begin bad++; $display("FAIL async_term got=%b exp=0", termination); end
        total++; if (r3 !== 32'd0) begin bad++; $display("FAIL async_r3 got=%h exp=0", r3); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", cycle_count); end
        total++; if (exit_code !== 32'd0) begin bad++; $display("FAIL async_exit_code got=%0d exp=0", exit_code); end
        step();
        rst = 1'b0;
        step();
        step();
        total++; if (cycle_count !== 32'd2) begin bad++; $display("FAIL restart_count got=%0d exp=2", cycle_count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        enable = 1'b0;
        wb_pc = 32'd0;
        wb_insn = 32'd0;
        wb_en = 1'b0;
        wb_reg = 5'd0;
        wb_data = 32'd0;
        termination_all = 2'b00;
        step();
        step();
        test_reset();
        rst = 1'b0;
        test_putc();
        test_r3_filter();
        test_report();
        test_other_hooks();
        test_exit();
        test_cross();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
